// File: rtl/opb_register_bank_simulink2ppc.sv
// opb_register_bank_simulink2ppc
//   OPB slave presenting C_N_CHANNELS coherent 32-bit snapshots of user words,
//   plus CTRL (trigger/auto) and STAT (missed flag, snapshot count) registers.
//   Define OPB_REG_BANK_TIMESTAMP_EN to build a free-running cycle counter that
//   is latched on every snapshot and read at offset 0x08+4*C_N_CHANNELS.
//
// Bus handshake: a select whose address lies in [C_BASEADDR, C_HIGHADDR] is
// registered in IDLE, answered with Sl_xferAck high for exactly one cycle (ACK),
// and the slave then sits in WAIT until OPB_select falls, so a held select is
// never acknowledged twice. Sl_DBus is zero outside the ack cycle. Writes take
// effect at the clock edge that ends ACK. Out-of-window selects get no response.
//
// OPB vectors are numbered big-endian ([0] is the MSB). Copying them into
// [31:0] vectors keeps bit significance, so DBus[31] becomes bit 0.
module opb_register_bank_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h01008500,
  parameter logic [31:0] C_HIGHADDR   = 32'h010085FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_N_CHANNELS = 4,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic [0:31]                 OPB_ABus,
  input  logic [0:3]                  OPB_BE,
  input  logic [0:31]                 OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:31]                 Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  input  logic [32*C_N_CHANNELS-1:0]  user_data_in,
  input  logic                        user_data_valid,
  output logic                        snap_pulse
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam int          N      = C_N_CHANNELS;
  localparam logic [29:0] IDX_TS = 30'(N + 2);

  // Family and bus widths carry no function; referenced only so they count as used.
  localparam logic unused_cfg = (C_OPB_AWIDTH == 32) && (C_OPB_DWIDTH == 32) && (C_FAMILY != "");

  logic [1:0]  state;
  logic [31:0] abus;
  logic [31:0] offset;
  logic [29:0] idx;
  logic        hit;

  logic [31:0] rd_mux;
  logic [31:0] rd_q;
  logic [29:0] idx_q;
  logic        rnw_q;
  logic [1:0]  wctl_q;     // [1]=auto bit (DBus[30]), [0]=trigger bit (DBus[31])
  logic        be_lsb_q;   // BE[3], the lane holding the CTRL bits

  logic        auto_en;
  logic        missed;
  logic [15:0] snap_count;
  logic [31:0] snap [N];
  logic [31:0] ts_rd;

  logic        commit;
  logic        ctrl_wr;
  logic        stat_wr;
  logic        trig;
  logic        cond;
  logic        missed_set;

  assign abus   = OPB_ABus;
  assign offset = abus - C_BASEADDR;
  assign idx    = offset[31:2];
  assign hit    = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

  assign commit     = (state == ST_ACK) && !rnw_q;
  assign ctrl_wr    = commit && (idx_q == 30'd0) && be_lsb_q;
  assign stat_wr    = commit && (idx_q == 30'd1);
  assign trig       = ctrl_wr && wctl_q[0];
  assign cond       = trig || (auto_en && user_data_valid);
  assign missed_set = user_data_valid && !auto_en && !ctrl_wr;

  assign snap_pulse = cond && !OPB_Rst;
  assign Sl_xferAck = (state == ST_ACK);
  assign Sl_DBus    = (state == ST_ACK) ? rd_q : 32'h0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, unused_cfg, OPB_seqAddr, offset[1:0], OPB_DBus[0:29], OPB_BE[0:2]};

`ifdef OPB_REG_BANK_TIMESTAMP_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ts_q;

  // Free-running cycle counter; its value is copied whenever a snapshot is taken.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      cyc_cnt <= 32'h0;
      ts_q    <= 32'h0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (cond) ts_q <= cyc_cnt;
    end
  end

  assign ts_rd = ts_q;
`else
  assign ts_rd = 32'h0;
`endif

  // Read mux over the register map; sampled into rd_q when a transfer is accepted.
  always_comb begin
    rd_mux = 32'h0;
    if (idx == 30'd0) begin
      rd_mux = {30'b0, auto_en, 1'b0};
    end else if (idx == 30'd1) begin
      rd_mux = {missed, 15'b0, snap_count};
    end else if (idx == IDX_TS) begin
      rd_mux = ts_rd;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (idx == 30'(i + 2)) rd_mux = snap[i];
      end
    end
  end

  // Bus FSM: IDLE accepts and registers the transfer, ACK acknowledges, WAIT holds off re-acks.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state    <= ST_IDLE;
      rd_q     <= 32'h0;
      idx_q    <= 30'h0;
      rnw_q    <= 1'b1;
      wctl_q   <= 2'b00;
      be_lsb_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            state    <= ST_ACK;
            rd_q     <= OPB_RNW ? rd_mux : 32'h0;
            idx_q    <= idx;
            rnw_q    <= OPB_RNW;
            wctl_q   <= {OPB_DBus[30], OPB_DBus[31]};
            be_lsb_q <= OPB_BE[3];
          end
        end
        ST_ACK:  state <= ST_WAIT;
        ST_WAIT: if (!OPB_select) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Control, sticky missed flag, and the coherent snapshot of all channels.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      auto_en    <= 1'b0;
      missed     <= 1'b0;
      snap_count <= 16'h0;
      for (int i = 0; i < N; i++) snap[i] <= 32'h0;
    end else begin
      if (ctrl_wr) auto_en <= wctl_q[1];
      if (stat_wr) missed <= 1'b0;
      if (missed_set) missed <= 1'b1;
      if (cond) begin
        snap_count <= snap_count + 16'd1;
        for (int i = 0; i < N; i++) snap[i] <= user_data_in[32*i +: 32];
      end
    end
  end

endmodule
